// File: rtl/lut3d_pkg.sv
// Shared types and lattice geometry helpers for the 3D-LUT corner fetch block.
package lut3d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    function automatic int unsigned lut_nodes(input int unsigned grid_bits);
        return (32'd1 << grid_bits) + 32'd1;
    endfunction

    function automatic int unsigned lut_addr_w(input int unsigned grid_bits);
        int unsigned n;
        n = lut_nodes(grid_bits);
        return $clog2(n * n * n);
    endfunction

    // Offset of corner k from the base node: bit0 -> +x, bit1 -> +y, bit2 -> +z.
    function automatic int unsigned corner_off(input int unsigned grid_bits, input int unsigned k);
        int unsigned n;
        int unsigned off;
        n   = lut_nodes(grid_bits);
        off = 0;
        if (k[0]) off = off + 1;
        if (k[1]) off = off + n;
        if (k[2]) off = off + n * n;
        return off;
    endfunction

endpackage

// File: rtl/lut3d_addr_gen.sv
// Combinational lattice address for corner k of the cell whose lowest node is (ix, iy, iz).
module lut3d_addr_gen
    import lut3d_pkg::*;
#(
    parameter int GRID_BITS = 4,
    parameter int ADDR_W    = lut_addr_w(GRID_BITS)
) (
    input  logic [GRID_BITS-1:0] ix_i,
    input  logic [GRID_BITS-1:0] iy_i,
    input  logic [GRID_BITS-1:0] iz_i,
    input  logic [2:0]           k_i,
    output logic [ADDR_W-1:0]    addr_o
);

    localparam int unsigned N = lut_nodes(GRID_BITS);
    localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] CORNER_OFF [8] = '{
        ADDR_W'(corner_off(GRID_BITS, 0)), ADDR_W'(corner_off(GRID_BITS, 1)),
        ADDR_W'(corner_off(GRID_BITS, 2)), ADDR_W'(corner_off(GRID_BITS, 3)),
        ADDR_W'(corner_off(GRID_BITS, 4)), ADDR_W'(corner_off(GRID_BITS, 5)),
        ADDR_W'(corner_off(GRID_BITS, 6)), ADDR_W'(corner_off(GRID_BITS, 7))
    };

    logic [ADDR_W-1:0] base;

    // Highest index is N-2, so base + largest offset stays within N^3-1.
    assign base   = (ADDR_W'(iz_i) * N_A + ADDR_W'(iy_i)) * N_A + ADDR_W'(ix_i);
    assign addr_o = base + CORNER_OFF[k_i];

endmodule

// File: rtl/lut3d_corner_fetch.sv
// Splits a 3-axis sample into lattice index/fraction and reads the 8 cell corners
// from a single-port synchronous LUT for the trilinear interpolator.
module lut3d_corner_fetch
    import lut3d_pkg::*;
#(
    parameter int IN_CD     = 8,
    parameter int GRID_BITS = 4,
    parameter int FW        = 8,
    parameter int RD_LAT    = 1,
    parameter int ADDR_W    = lut_addr_w(GRID_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_CD-1:0]      in_x,
    input  logic [IN_CD-1:0]      in_y,
    input  logic [IN_CD-1:0]      in_z,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [IN_CD-1:0]      rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0][IN_CD-1:0] pt_nbr,
    output logic [FW-1:0]         frac_x,
    output logic [FW-1:0]         frac_y,
    output logic [FW-1:0]         frac_z,
    output state_e                dbg_state
);

    localparam int FL = IN_CD - GRID_BITS;

    state_e                 state_q, state_d;
    logic [GRID_BITS-1:0]   ix_q, iy_q, iz_q;
    logic [FW-1:0]          fx_q, fy_q, fz_q;
    logic [2:0]             k_q, k_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [3:0]             cap_cnt_q;
    logic                   pipe_v_q [RD_LAT];
    logic [2:0]             pipe_k_q [RD_LAT];
    logic [7:0][IN_CD-1:0]  pt_q;

    logic                   accept;
    logic                   cap_fire;
    logic [2:0]             cap_k;
    logic [GRID_BITS-1:0]   ag_x, ag_y, ag_z;
    logic [2:0]             ag_k;
    logic [ADDR_W-1:0]      ag_addr;

    // Both handshakes transfer on a clock edge where valid and ready are high together;
    // a producer holds valid and its payload steady until that edge.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign pt_nbr    = pt_q;
    assign frac_x    = fx_q;
    assign frac_y    = fy_q;
    assign frac_z    = fz_q;
    assign dbg_state = state_q;
    assign cap_fire  = pipe_v_q[RD_LAT-1];
    assign cap_k     = pipe_k_q[RD_LAT-1];

    // Corner 0 is addressed straight from the incoming sample so it issues the cycle after accept.
    always_comb begin
        ag_x = ix_q;
        ag_y = iy_q;
        ag_z = iz_q;
        ag_k = k_q + 3'd1;
        if (state_q == ST_IDLE) begin
            ag_x = in_x[IN_CD-1 -: GRID_BITS];
            ag_y = in_y[IN_CD-1 -: GRID_BITS];
            ag_z = in_z[IN_CD-1 -: GRID_BITS];
            ag_k = 3'd0;
        end
    end

    lut3d_addr_gen #(
        .GRID_BITS (GRID_BITS),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .ix_i   (ag_x),
        .iy_i   (ag_y),
        .iz_i   (ag_z),
        .k_i    (ag_k),
        .addr_o (ag_addr)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_ISSUE;
                    k_d       = 3'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ag_addr;
                end
            end
            ST_ISSUE: begin
                if (k_q == 3'd7) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d       = k_q + 3'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ag_addr;
                end
            end
            ST_DRAIN: begin
                if (cap_fire && cap_cnt_q == 4'd7) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= 3'd0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            ix_q      <= '0;
            iy_q      <= '0;
            iz_q      <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            fz_q      <= '0;
            cap_cnt_q <= 4'd0;
            pt_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_k_q[i] <= 3'd0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            if (accept) begin
                ix_q      <= in_x[IN_CD-1 -: GRID_BITS];
                iy_q      <= in_y[IN_CD-1 -: GRID_BITS];
                iz_q      <= in_z[IN_CD-1 -: GRID_BITS];
                fx_q      <= FW'(in_x[FL-1:0]) << (FW - FL);
                fy_q      <= FW'(in_y[FL-1:0]) << (FW - FL);
                fz_q      <= FW'(in_z[FL-1:0]) << (FW - FL);
                cap_cnt_q <= 4'd0;
            end else if (cap_fire) begin
                cap_cnt_q <= cap_cnt_q + 4'd1;
            end
            // The tag travels with each read so the return lands in the right corner slot.
            pipe_v_q[0] <= rd_en_q;
            pipe_k_q[0] <= k_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_k_q[i] <= pipe_k_q[i-1];
            end
            if (cap_fire) pt_q[cap_k] <= rd_data;
        end
    end

endmodule

// File: tb/tb_lut3d_corner_fetch.sv
// Self-checking bench for lut3d_corner_fetch: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_lut3d_corner_fetch;
  import lut3d_pkg::*;

  localparam int W = 88;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // instance with RD_LAT = 1
  logic            in_valid1 = 1'b0, in_ready1;
  logic [7:0]      in_x1 = '0, in_y1 = '0, in_z1 = '0;
  logic            rd_en1;
  logic [12:0]     rd_addr1;
  logic [7:0]      rd_data1;
  logic            out_valid1, out_ready1 = 1'b1;
  logic [7:0][7:0] pt_nbr1;
  logic [7:0]      frac_x1, frac_y1, frac_z1;
  state_e          dbg_state1;

  // instance with RD_LAT = 3
  logic            in_valid3 = 1'b0, in_ready3;
  logic [7:0]      in_x3 = '0, in_y3 = '0, in_z3 = '0;
  logic            rd_en3;
  logic [12:0]     rd_addr3;
  logic [7:0]      rd_data3;
  logic            out_valid3, out_ready3 = 1'b1;
  logic [7:0][7:0] pt_nbr3;
  logic [7:0]      frac_x3, frac_y3, frac_z3;
  state_e          dbg_state3;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp3_q[$];
  logic [12:0]   addr_log[$];
  int            en_log[$];

  // ---------------- clock / reset / memory models ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m1_q;
  logic [7:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= rd_en1 ? rd_addr1[7:0] : 8'hEE;
    m3_q[0] <= rd_en3 ? rd_addr3[7:0] : 8'hEE;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rd_data1 = m1_q;
  assign rd_data3 = m3_q[2];

  always @(negedge clk) begin
    if (rd_en1) begin
      addr_log.push_back(rd_addr1);
      en_log.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  lut3d_corner_fetch #(.IN_CD(8), .GRID_BITS(4), .FW(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_x(in_x1), .in_y(in_y1), .in_z(in_z1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .pt_nbr(pt_nbr1),
    .frac_x(frac_x1), .frac_y(frac_y1), .frac_z(frac_z1), .dbg_state(dbg_state1)
  );

  lut3d_corner_fetch #(.IN_CD(8), .GRID_BITS(4), .FW(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_x(in_x3), .in_y(in_y3), .in_z(in_z3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .pt_nbr(pt_nbr3),
    .frac_x(frac_x3), .frac_y(frac_y3), .frac_z(frac_z3), .dbg_state(dbg_state3)
  );

  // ---------------- reference model ----------------
  function automatic logic [12:0] exp_addr(input logic [7:0] x, y, z, input int k);
    int ix, iy, iz;
    ix = int'(x[7:4]) + (k % 2);
    iy = int'(y[7:4]) + ((k / 2) % 2);
    iz = int'(z[7:4]) + (k / 4);
    return 13'((iz * 17 + iy) * 17 + ix);
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic [7:0] x, y, z);
    logic [W-1:0] v;
    logic [12:0]  a;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      a = exp_addr(x, y, z, k);
      v[24 + 8*k +: 8] = a[7:0];
    end
    v[23:16] = {x[3:0], 4'h0};
    v[15:8]  = {y[3:0], 4'h0};
    v[7:0]   = {z[3:0], 4'h0};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send1(input logic [7:0] x, y, z, output int t_acc);
    int guard;
    guard = 0;
    t_acc = -1;
    @(negedge clk);
    in_x1 = x; in_y1 = y; in_z1 = z; in_valid1 = 1'b1;
    while (t_acc < 0 && guard < 100) begin
      if (in_ready1) t_acc = cyc;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    n_checks++;
    if (t_acc < 0) begin
      n_errors++;
      $display("FAIL send1_accept: in_ready stayed 0, required 1 within 100 cycles");
    end else begin
      exp_q.push_back(exp_vec(x, y, z));
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
  endtask

  task automatic wait_out1(output int t_ov);
    t_ov = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid1) begin
        t_ov = cyc;
        break;
      end
    end
  endtask

  task automatic run_sample(input string name, input logic [7:0] x, y, z);
    int t, to;
    logic [W-1:0] e;
    addr_log.delete();
    en_log.delete();
    send1(x, y, z, t);
    wait_out1(to);
    n_checks++;
    if (to != t + 10) begin
      n_errors++;
      $display("FAIL %s_latency: out_valid cycle %0d, required %0d", name, to, t + 10);
    end
    n_checks++;
    if (addr_log.size() != 8) begin
      n_errors++;
      $display("FAIL %s_read_count: %0d reads, required 8", name, addr_log.size());
    end
    for (int k = 0; k < 8; k++) begin
      if (k < addr_log.size()) begin
        n_checks++;
        if (addr_log[k] !== exp_addr(x, y, z, k)) begin
          n_errors++;
          $display("FAIL %s_rd_addr%0d: got %0d, required %0d", name, k, addr_log[k], exp_addr(x, y, z, k));
        end
        n_checks++;
        if (en_log[k] != t + 1 + k) begin
          n_errors++;
          $display("FAIL %s_rd_cycle%0d: got %0d, required %0d", name, k, en_log[k], t + 1 + k);
        end
      end
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_scoreboard: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      if ({pt_nbr1, frac_x1, frac_y1, frac_z1} !== e) begin
        n_errors++;
        $display("FAIL %s_data: got %h, required %h", name, {pt_nbr1, frac_x1, frac_y1, frac_z1}, e);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_handshake: out_valid=%b in_ready=%b, required 0/1", name, out_valid1, in_ready1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid1 !== 1'b0 || rd_en1 !== 1'b0 || rd_addr1 !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_ctrl: out_valid=%b rd_en=%b rd_addr=%0d, required 0/0/0", out_valid1, rd_en1, rd_addr1);
    end
    n_checks++;
    if ({pt_nbr1, frac_x1, frac_y1, frac_z1} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got %h, required 0", {pt_nbr1, frac_x1, frac_y1, frac_z1});
    end
    n_checks++;
    if (in_ready1 !== 1'b0 || in_ready3 !== 1'b0 || out_valid3 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_ready: in_ready1=%b in_ready3=%b out_valid3=%b, required 0/0/0", in_ready1, in_ready3, out_valid3);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready1 !== 1'b1 || in_ready3 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: in_ready1=%b in_ready3=%b, required 1/1", in_ready1, in_ready3);
    end
  endtask

  task automatic test_origin;
    run_sample("origin", 8'h00, 8'h00, 8'h00);
    n_checks++;
    if (pt_nbr1[7] !== 8'h33 || {frac_x1, frac_y1, frac_z1} !== 24'h0) begin
      n_errors++;
      $display("FAIL origin_corner7: pt7=%h frac=%h, required 33/000000", pt_nbr1[7], {frac_x1, frac_y1, frac_z1});
    end
  endtask

  task automatic test_max_corner;
    logic [12:0] mx;
    run_sample("max", 8'hFF, 8'hFF, 8'hFF);
    mx = '0;
    foreach (addr_log[i]) if (addr_log[i] > mx) mx = addr_log[i];
    n_checks++;
    if (mx !== 13'd4912) begin
      n_errors++;
      $display("FAIL max_top_addr: got %0d, required 4912", mx);
    end
    n_checks++;
    if ({frac_x1, frac_y1, frac_z1} !== 24'hF0F0F0) begin
      n_errors++;
      $display("FAIL max_frac: got %h, required f0f0f0", {frac_x1, frac_y1, frac_z1});
    end
  endtask

  task automatic test_mid;
    run_sample("mid", 8'h12, 8'h34, 8'h56);
    n_checks++;
    if (addr_log.size() == 0 || addr_log[0] !== 13'd1497) begin
      n_errors++;
      $display("FAIL mid_first_addr: got %0d, required 1497", addr_log.size() ? addr_log[0] : 13'h1FFF);
    end
    n_checks++;
    if ({frac_x1, frac_y1, frac_z1} !== 24'h204060) begin
      n_errors++;
      $display("FAIL mid_frac: got %h, required 204060", {frac_x1, frac_y1, frac_z1});
    end
  endtask

  task automatic test_backpressure;
    int t, to, bad;
    logic [7:0] x, y, z;
    logic [W-1:0] held, e;
    x = 8'($urandom_range(0, 255));
    y = 8'($urandom_range(0, 255));
    z = 8'($urandom_range(0, 255));
    @(negedge clk);
    out_ready1 = 1'b0;
    send1(x, y, z, t);
    wait_out1(to);
    held = {pt_nbr1, frac_x1, frac_y1, frac_z1};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL bp_scoreboard: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      if (held !== e) begin
        n_errors++;
        $display("FAIL bp_data: got %h, required %h", held, e);
      end
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || rd_en1 !== 1'b0 ||
          {pt_nbr1, frac_x1, frac_y1, frac_z1} !== held) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_reset_mid;
    int t, seen;
    logic [7:0] x, y, z;
    x = 8'($urandom_range(32, 255));
    y = 8'($urandom_range(32, 255));
    z = 8'($urandom_range(32, 255));
    send1(x, y, z, t);
    for (int i = 0; i < 20 && cyc < t + 5; i++) @(negedge clk);
    n_checks++;
    if (rd_en1 !== 1'b1 || rd_addr1 !== exp_addr(x, y, z, 4)) begin
      n_errors++;
      $display("FAIL rstmid_corner4: rd_en=%b rd_addr=%0d, required 1/%0d", rd_en1, rd_addr1, exp_addr(x, y, z, 4));
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_en1 !== 1'b0 || in_ready1 !== 1'b0 || pt_nbr1 !== '0) begin
      n_errors++;
      $display("FAIL rstmid_abort: rd_en=%b in_ready=%b pt=%h, required 0/0/0", rd_en1, in_ready1, pt_nbr1);
    end
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid1 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL rstmid_no_output: out_valid high %0d cycles, required 0", seen);
    end
    run_sample("after_reset", 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back;
    logic [7:0] sx[2], sy[2], sz[2];
    int acc[2], ov[2];
    int na, no;
    logic acc_now;
    logic [W-1:0] e;
    na = 0; no = 0;
    for (int i = 0; i < 2; i++) begin
      sx[i] = 8'($urandom_range(0, 255));
      sy[i] = 8'($urandom_range(0, 255));
      sz[i] = 8'($urandom_range(0, 255));
      acc[i] = -100;
      ov[i] = -100;
    end
    @(negedge clk);
    out_ready3 = 1'b1;
    in_x3 = sx[0]; in_y3 = sy[0]; in_z3 = sz[0]; in_valid3 = 1'b1;
    for (int i = 0; i < 80 && no < 2; i++) begin
      acc_now = in_valid3 && in_ready3;
      if (acc_now) begin
        acc[na] = cyc;
        exp3_q.push_back(exp_vec(sx[na], sy[na], sz[na]));
        na++;
      end
      if (out_valid3 && out_ready3) begin
        ov[no] = cyc;
        n_checks++;
        if (exp3_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_scoreboard%0d: output with nothing expected", no);
        end else begin
          e = exp3_q.pop_front();
          if ({pt_nbr3, frac_x3, frac_y3, frac_z3} !== e) begin
            n_errors++;
            $display("FAIL b2b_data%0d: got %h, required %h", no, {pt_nbr3, frac_x3, frac_y3, frac_z3}, e);
          end
        end
        no++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (na < 2) begin
          in_x3 = sx[na]; in_y3 = sy[na]; in_z3 = sz[na];
        end else begin
          in_valid3 = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid3 = 1'b0;
    n_checks++;
    if (no != 2) begin
      n_errors++;
      $display("FAIL b2b_count: %0d outputs, required 2", no);
    end
    n_checks++;
    if (ov[0] != acc[0] + 12) begin
      n_errors++;
      $display("FAIL b2b_latency0: out_valid cycle %0d, required %0d", ov[0], acc[0] + 12);
    end
    n_checks++;
    if (acc[1] != ov[0] + 1) begin
      n_errors++;
      $display("FAIL b2b_second_accept: cycle %0d, required %0d", acc[1], ov[0] + 1);
    end
    n_checks++;
    if (ov[1] != acc[1] + 12) begin
      n_errors++;
      $display("FAIL b2b_latency1: out_valid cycle %0d, required %0d", ov[1], acc[1] + 12);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_origin();
    test_max_corner();
    test_mid();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
